// File: rtl/multi_cell_scaler_if.sv
// Stream and configuration bundle for multi_cell_scaler.
// The slave modport is the scaler's view; the master modport is the producer/consumer view.
interface multi_cell_scaler_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int INDEX_WIDTH  = 10,
    parameter int SCALE_WIDTH  = 16,
    parameter int SHIFT_WIDTH  = 5
);
    logic                    cfg_load;
    logic [SCALE_WIDTH-1:0]  cfg_scale;
    logic [SHIFT_WIDTH-1:0]  cfg_shift;
    logic [DATA_WIDTH-1:0]   cfg_offset;
    logic                    index_clear;
    logic                    in_valid;
    logic                    in_ready;
    logic [RESULT_WIDTH-1:0] in_result;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_value;
    logic [INDEX_WIDTH-1:0]  out_index;
    logic                    out_last;

    modport slave (
        input  cfg_load, cfg_scale, cfg_shift, cfg_offset, index_clear,
        input  in_valid, in_result, out_ready,
        output in_ready, out_valid, out_value, out_index, out_last
    );

    modport master (
        output cfg_load, cfg_scale, cfg_shift, cfg_offset, index_clear,
        output in_valid, in_result, out_ready,
        input  in_ready, out_valid, out_value, out_index, out_last
    );
endinterface

// File: rtl/multi_cell_scaler.sv
// multi_cell_scaler: requantises unsigned accumulator results into DATA_WIDTH activations,
// value = sat((result*scale >> shift) + offset), through a 2-stage valid/ready pipeline.
// Each beat carries a wrapping cell index and a last flag.
// Optional build macro SCALER_ROUND_EN: round half-up before the shift (default: floor).
module multi_cell_scaler #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int INDEX_WIDTH  = 10,
    parameter int SCALE_WIDTH  = 16,
    parameter int SHIFT_WIDTH  = 5,
    parameter int CELL_AMOUNT  = 4
) (
    input logic                clk,
    input logic                rst_n,
    multi_cell_scaler_if.slave bus
);
    localparam int PROD_W = RESULT_WIDTH + SCALE_WIDTH;
    // one bit of headroom for the rounding bias, one more for the offset add
    localparam int SUM_W  = PROD_W + 2;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(CELL_AMOUNT - 1);

    // Shift the product right (optionally rounding) and add the offset, no overflow possible.
    function automatic logic [SUM_W-1:0] shift_offset(
        input logic [PROD_W-1:0]      prod,
        input logic [SHIFT_WIDTH-1:0] shift,
        input logic [DATA_WIDTH-1:0]  offset
    );
        logic [PROD_W:0] biased;
        logic [PROD_W:0] shifted;
        biased = {1'b0, prod};
`ifdef SCALER_ROUND_EN
        if (shift != '0) begin
            biased = biased + ((PROD_W + 1)'(1) << (shift - SHIFT_WIDTH'(1)));
        end
`endif
        // shifting by the full product width or more leaves nothing
        if (32'(shift) >= PROD_W) begin
            shifted = '0;
        end else begin
            shifted = biased >> shift;
        end
        return SUM_W'(shifted) + SUM_W'(offset);
    endfunction

    // Clamp to the largest DATA_WIDTH value.
    function automatic logic [DATA_WIDTH-1:0] saturate(input logic [SUM_W-1:0] sum);
        if (|sum[SUM_W-1:DATA_WIDTH]) begin
            return '1;
        end
        return sum[DATA_WIDTH-1:0];
    endfunction

    // control state
    logic                    vld_p1_q, vld_p1_d;
    logic                    vld_p2_q, vld_p2_d;
    logic [INDEX_WIDTH-1:0]  idx_cnt_q, idx_cnt_d;
    logic [SCALE_WIDTH-1:0]  cfg_scale_q, cfg_scale_d;
    logic [SHIFT_WIDTH-1:0]  cfg_shift_q, cfg_shift_d;
    logic [DATA_WIDTH-1:0]   cfg_offset_q, cfg_offset_d;
    // datapath state
    logic [PROD_W-1:0]       prod_p1_q, prod_p1_d;
    logic [INDEX_WIDTH-1:0]  idx_p1_q, idx_p1_d;
    logic [SHIFT_WIDTH-1:0]  shift_p1_q, shift_p1_d;
    logic [DATA_WIDTH-1:0]   offset_p1_q, offset_p1_d;
    logic [DATA_WIDTH-1:0]   value_p2_q, value_p2_d;
    logic [INDEX_WIDTH-1:0]  idx_p2_q, idx_p2_d;
    logic                    last_p2_q, last_p2_d;

    logic                    s2_adv, s1_adv, accept;
    logic [INDEX_WIDTH-1:0]  beat_idx;

    // Pipeline advance conditions; in_ready is the only path from out_ready.
    always_comb begin
        s2_adv = !vld_p2_q || bus.out_ready;
        s1_adv = !vld_p1_q || s2_adv;
        accept = bus.in_valid && s1_adv;
    end

    // Cell index counter: clear restarts at 0 and applies to a same-cycle accept.
    always_comb begin
        beat_idx  = bus.index_clear ? '0 : idx_cnt_q;
        idx_cnt_d = idx_cnt_q;
        if (accept) begin
            idx_cnt_d = (beat_idx == LAST_IDX) ? '0 : beat_idx + INDEX_WIDTH'(1);
        end else if (bus.index_clear) begin
            idx_cnt_d = '0;
        end
    end

    // Runtime configuration; affects beats accepted from the following cycle.
    always_comb begin
        cfg_scale_d  = cfg_scale_q;
        cfg_shift_d  = cfg_shift_q;
        cfg_offset_d = cfg_offset_q;
        if (bus.cfg_load) begin
            cfg_scale_d  = bus.cfg_scale;
            cfg_shift_d  = bus.cfg_shift;
            cfg_offset_d = bus.cfg_offset;
        end
    end

    // Stage 1: full-width product plus the config and index travelling with the beat.
    always_comb begin
        vld_p1_d    = s1_adv ? accept : vld_p1_q;
        prod_p1_d   = prod_p1_q;
        idx_p1_d    = idx_p1_q;
        shift_p1_d  = shift_p1_q;
        offset_p1_d = offset_p1_q;
        if (accept) begin
            prod_p1_d   = PROD_W'(bus.in_result) * PROD_W'(cfg_scale_q);
            idx_p1_d    = beat_idx;
            shift_p1_d  = cfg_shift_q;
            offset_p1_d = cfg_offset_q;
        end
    end

    // Stage 2: shift, offset and saturate; held while the consumer stalls.
    always_comb begin
        vld_p2_d   = s2_adv ? vld_p1_q : vld_p2_q;
        value_p2_d = value_p2_q;
        idx_p2_d   = idx_p2_q;
        last_p2_d  = last_p2_q;
        if (s2_adv && vld_p1_q) begin
            value_p2_d = saturate(shift_offset(prod_p1_q, shift_p1_q, offset_p1_q));
            idx_p2_d   = idx_p1_q;
            last_p2_d  = (idx_p1_q == LAST_IDX);
        end
    end

    // Control registers: valids, index counter and config come up in a known state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            idx_cnt_q    <= '0;
            cfg_scale_q  <= SCALE_WIDTH'(1);
            cfg_shift_q  <= '0;
            cfg_offset_q <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            idx_cnt_q    <= idx_cnt_d;
            cfg_scale_q  <= cfg_scale_d;
            cfg_shift_q  <= cfg_shift_d;
            cfg_offset_q <= cfg_offset_d;
        end
    end

    // Datapath registers: qualified by the valids, so no reset needed.
    always_ff @(posedge clk) begin
        prod_p1_q   <= prod_p1_d;
        idx_p1_q    <= idx_p1_d;
        shift_p1_q  <= shift_p1_d;
        offset_p1_q <= offset_p1_d;
        value_p2_q  <= value_p2_d;
        idx_p2_q    <= idx_p2_d;
        last_p2_q   <= last_p2_d;
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = vld_p2_q;
    assign bus.out_value = vld_p2_q ? value_p2_q : '0;
    assign bus.out_index = vld_p2_q ? idx_p2_q : '0;
    assign bus.out_last  = vld_p2_q && last_p2_q;
endmodule

// File: tb/tb_multi_cell_scaler.sv
// Testbench for multi_cell_scaler (CELL_AMOUNT=2): directed table, hand sequences, random stream.
module tb_multi_cell_scaler;
    localparam int DW = 8, RW = 16, IW = 10, SCW = 16, SHW = 5, CA = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_cell_scaler_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .INDEX_WIDTH(IW),
                           .SCALE_WIDTH(SCW), .SHIFT_WIDTH(SHW)) bus ();

    multi_cell_scaler #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .INDEX_WIDTH(IW),
                        .SCALE_WIDTH(SCW), .SHIFT_WIDTH(SHW), .CELL_AMOUNT(CA)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int unsigned val;
        int unsigned idx;
        bit          last;
        int          cyc;
    } exp_t;

    typedef struct {
        int unsigned scale, shift, offset, result, expv;
    } vec_t;

    int n_chk = 0, n_fail = 0, cyc = 0;
    exp_t exp_q[$];
    int unsigned m_scale = 1, m_shift = 0, m_offset = 0, m_idx = 0;
    bit held = 0, last_acc = 0, force_en = 0;
    int unsigned force_val = 0;
    logic [DW-1:0] h_val;
    logic [IW-1:0] h_idx;
    logic          h_last;

    // Reference: the requantisation rule in plain wide arithmetic.
    function automatic int unsigned model_val(longint unsigned r, longint unsigned sc,
                                              int unsigned sh, longint unsigned off);
        longint unsigned p, s;
        p = r * sc;
`ifdef SCALER_ROUND_EN
        if (sh > 0) p = p + (64'd1 << (sh - 1));
`endif
        s = (sh >= RW + SCW) ? 64'd0 : (p >> sh);
        s = s + off;
        return (s > 255) ? 255 : int'(s);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event missing expected event present (cycle %0d)", name, cyc);
    endtask

    // One clock: check outputs against the scoreboard, update the model, advance.
    task automatic tick();
        exp_t e;
        bit acc, pop;
        int unsigned bidx;
        #1;
        acc = bus.in_valid && bus.in_ready;
        pop = bus.out_valid && bus.out_ready;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2 || bus.out_ready));
        chk("out_valid", 64'(bus.out_valid),
            64'(exp_q.size() > 0 && (cyc - exp_q[0].cyc) >= 2));
        if (!bus.out_valid) begin
            chk("idle_zero", 64'({bus.out_value, bus.out_index, bus.out_last}), 64'd0);
        end else if (held) begin
            chk("hold_value", 64'(bus.out_value), 64'(h_val));
            chk("hold_index", 64'(bus.out_index), 64'(h_idx));
            chk("hold_last", 64'(bus.out_last), 64'(h_last));
        end
        if (pop) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                chk("value", 64'(bus.out_value), 64'(exp_q[0].val));
                chk("index", 64'(bus.out_index), 64'(exp_q[0].idx));
                chk("last", 64'(bus.out_last), 64'(exp_q[0].last));
                void'(exp_q.pop_front());
            end
        end
        held   = bus.out_valid && !bus.out_ready;
        h_val  = bus.out_value;
        h_idx  = bus.out_index;
        h_last = bus.out_last;
        bidx = bus.index_clear ? 0 : m_idx;
        if (acc) begin
            e.val  = force_en ? force_val : model_val(bus.in_result, m_scale, m_shift, m_offset);
            e.idx  = bidx;
            e.last = (bidx == CA - 1);
            e.cyc  = cyc;
            exp_q.push_back(e);
            m_idx = (bidx + 1) % CA;
        end else if (bus.index_clear) begin
            m_idx = 0;
        end
        if (bus.cfg_load) begin
            m_scale  = bus.cfg_scale;
            m_shift  = bus.cfg_shift;
            m_offset = bus.cfg_offset;
        end
        last_acc = acc;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.cfg_load    = 1'b0;
        bus.index_clear = 1'b0;
    endtask

    task automatic send_beat(int unsigned r, bit fe, int unsigned fv);
        bus.in_valid  = 1'b1;
        bus.in_result = RW'(r);
        force_en      = fe;
        force_val     = fv;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) fail_now("accept_timeout");
        bus.in_valid = 1'b0;
        force_en     = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) fail_now("drain_timeout");
        tick();
    endtask

    task automatic load_cfg(int unsigned sc, int unsigned sh, int unsigned off);
        bus.cfg_scale  = SCW'(sc);
        bus.cfg_shift  = SHW'(sh);
        bus.cfg_offset = DW'(off);
        bus.cfg_load   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int sent;
        int unsigned data6[6];
        vecs = '{
            '{10, 1, 10, 60, 255},
            '{16'hFFFF, 0, 0, 16'hFFFF, 255},
`ifdef SCALER_ROUND_EN
            '{3, 1, 10, 1, 12},
`else
            '{3, 1, 10, 1, 11},
`endif
            '{3, 1, 10, 2, 13},
            '{1, 0, 0, 200, 200},
            '{1, 31, 7, 16'hFFFF, 7},
            '{2, 1, 0, 255, 255},
            '{1, 0, 1, 255, 255},
            '{1, 0, 0, 0, 0}
        };
        data6 = '{10, 20, 30, 40, 50, 60};
        bus.cfg_load = 0; bus.cfg_scale = 0; bus.cfg_shift = 0; bus.cfg_offset = 0;
        bus.index_clear = 0; bus.in_valid = 0; bus.in_result = 0; bus.out_ready = 1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_outputs", 64'({bus.out_value, bus.out_index, bus.out_last}), 64'd0);
        rst_n = 1'b1;
        tick();

        // test 1: back-to-back stream, 2-cycle latency checked per tick
        load_cfg(10, 1, 10);
        tick();
        send_beat(1, 1, 15);
        send_beat(5, 1, 35);
        send_beat(0, 1, 10);
        send_beat(3, 1, 25);
        drain();

        // directed table: saturation, rounding, shift limits
        foreach (vecs[i]) begin
            load_cfg(vecs[i].scale, vecs[i].shift, vecs[i].offset);
            tick();
            send_beat(vecs[i].result, 1, vecs[i].expv);
            drain();
        end

        // test 4: six beats with a 3-cycle consumer stall mid-stream
        load_cfg(10, 1, 10);
        tick();
        sent = 0;
        for (int t = 0; t < 16 && sent < 6; t++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = RW'(data6[sent]);
            bus.out_ready = !(t >= 3 && t < 6);
            tick();
            if (last_acc) sent++;
        end
        bus.in_valid = 1'b0;
        chk("stall_sent", 64'(sent), 64'd6);
        drain();

        // test 5: index_clear with a concurrent accept, then mid-stream cfg_load
        bus.index_clear = 1'b1;
        tick();
        send_beat(11, 0, 0);
        bus.index_clear = 1'b1;
        send_beat(12, 0, 0);
        send_beat(13, 0, 0);
        send_beat(4, 1, 30);
        load_cfg(20, 0, 3);
        send_beat(4, 1, 30);
        send_beat(4, 1, 83);
        drain();

        // test 6: reset with two beats in flight
        bus.out_ready = 1'b1;
        send_beat(5, 0, 0);
        send_beat(6, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_outputs", 64'({bus.out_value, bus.out_index, bus.out_last}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        held = 0; m_idx = 0; m_scale = 1; m_shift = 0; m_offset = 0;
        tick();
        send_beat(77, 1, 77);
        drain();

        // random stream against the model
        for (int t = 0; t < 400; t++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_result = RW'($urandom);
            bus.out_ready = ($urandom % 3) != 0;
            if (($urandom % 16) == 0) begin
                load_cfg($urandom_range(0, 300),
                         (($urandom % 8) == 0) ? 31 : $urandom_range(0, 12),
                         $urandom_range(0, 255));
            end
            bus.index_clear = ($urandom % 20) == 0;
            tick();
        end
        bus.in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
